// File: rtl/hc_enc_rr_sched.sv
// hc_enc_rr_sched: round-robin scheduler that shares one Hamming(7,4)
// encoder among N_REQ nibble requesters and presents the registered
// codeword, tagged with the winner's index, on one valid/ready stream.
// Optional feature macro: HC_ENC_RR_XPAR_EN adds an overall parity bit
// (bit 8) to the codeword for SECDED use downstream.

// Hamming(7,4) encoder; codeword bit k is code position k.
module hc_enc (
  input  logic [3:0] i_data,
  output logic [7:1] o_code
);
  assign o_code[3] = i_data[0];
  assign o_code[5] = i_data[1];
  assign o_code[6] = i_data[2];
  assign o_code[7] = i_data[3];
  assign o_code[1] = i_data[0] ^ i_data[1] ^ i_data[3];
  assign o_code[2] = i_data[0] ^ i_data[2] ^ i_data[3];
  assign o_code[4] = i_data[1] ^ i_data[2] ^ i_data[3];
endmodule

module hc_enc_rr_sched #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [4*N_REQ-1:0]   i_req_data,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
`ifdef HC_ENC_RR_XPAR_EN
  output logic [8:1]           o_enc_data,
`else
  output logic [7:1]           o_enc_data,
`endif
  output logic [ID_W-1:0]      o_grant_id
);

`ifdef HC_ENC_RR_XPAR_EN
  localparam int CW_HI = 8;
`else
  localparam int CW_HI = 7;
`endif

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW_HI:1]    cw_q;
  logic [ID_W-1:0]   id_q;

  logic              any_valid;
  logic [ID_W-1:0]   win;
  logic              can_load;
  logic              load;
  logic [3:0]        win_data;
  logic [7:1]        enc_code;
  logic [CW_HI:1]    enc_full;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_valid && i_req_valid[idx]) begin
        any_valid = 1'b1;
        win       = ID_W'(idx);
      end
    end
  end

  // The output register can take a new codeword when empty or being popped.
  // Reset also blocks acceptance so nothing is handshaken while it is held.
  assign can_load    = (state_q == ST_EMPTY) || i_ready;
  assign load        = can_load && any_valid && !i_rst;
  assign o_req_ready = load ? ({{(N_REQ-1){1'b0}}, 1'b1} << win) : '0;

  assign win_data = i_req_data[{win, 2'b00} +: 4];

  hc_enc u_hc_enc (
    .i_data (win_data),
    .o_code (enc_code)
  );

`ifdef HC_ENC_RR_XPAR_EN
  assign enc_full = {^enc_code, enc_code};
`else
  assign enc_full = enc_code;
`endif

  // Next state: a load always fills (even while popping); a bare pop drains.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      state_d  = ST_FULL;
      rr_ptr_d = (win == ID_W'(N_REQ-1)) ? '0 : win + 1'b1;
    end else if ((state_q == ST_FULL) && i_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State, pointer and codeword registers; reset discards any held codeword.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      cw_q     <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (load) begin
        cw_q <= enc_full;
        id_q <= win;
      end
    end
  end

  assign o_valid    = (state_q == ST_FULL);
  assign o_enc_data = cw_q;
  assign o_grant_id = id_q;

endmodule

// File: tb/tb_hc_enc_rr_sched.sv
// Directed bench for hc_enc_rr_sched: expected codewords are queued when a
// request is issued and a monitor pops/compares on every output handshake.
module tb_hc_enc_rr_sched;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
`ifdef HC_ENC_RR_XPAR_EN
  localparam int CW_W = 8;
`else
  localparam int CW_W = 7;
`endif

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b1;
  logic [N_REQ-1:0]    i_req_valid = '0;
  logic [4*N_REQ-1:0]  i_req_data = '0;
  logic [N_REQ-1:0]    o_req_ready;
  logic                o_valid;
  logic                i_ready = 1'b0;
  logic [CW_W-1:0]     o_enc_data;
  logic [ID_W-1:0]     o_grant_id;

  int n_checks = 0;
  int n_errors = 0;

  logic [ID_W+CW_W-1:0] sb_q[$];

  hc_enc_rr_sched #(.N_REQ(N_REQ)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_enc_data  (o_enc_data),
    .o_grant_id  (o_grant_id)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hand-written 7-bit codeword, extended with overall parity when enabled.
  function automatic logic [CW_W-1:0] cw(input logic [6:0] c);
`ifdef HC_ENC_RR_XPAR_EN
    return {^c, c};
`else
    return c;
`endif
  endfunction

  function automatic void push(input int id, input logic [CW_W-1:0] c);
    sb_q.push_back({ID_W'(id), c});
  endfunction

  // Monitor: every output handshake must match the oldest expected entry.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_output", 32'(o_grant_id), 32'hFFFF_FFFF);
      end else begin
        logic [ID_W+CW_W-1:0] e;
        e = sb_q.pop_front();
        check("sb_grant_id", 32'(o_grant_id), 32'(e[ID_W+CW_W-1:CW_W]));
        check("sb_enc_data", 32'(o_enc_data), 32'(e[CW_W-1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Single-lane request; waits (bounded) for its grant, then withdraws.
  task automatic send(input int lane, input logic [3:0] d, input logic [CW_W-1:0] exp);
    int n;
    i_req_data[4*lane +: 4] = d;
    i_req_valid[lane] = 1'b1;
    push(lane, exp);
    n = 0;
    @(negedge i_clk);
    while (!o_req_ready[lane] && n < 20) begin
      n++;
      @(negedge i_clk);
    end
    if (!o_req_ready[lane]) check("send_grant_timeout", 32'(lane), 32'hFFFF_FFFF);
    tick();
    i_req_valid[lane] = 1'b0;
    check("send_latency_valid", 32'(o_valid), 32'd1);
  endtask

  initial begin
    logic [3:0] oh [5];
    oh[0] = 4'b0001; oh[1] = 4'b0010; oh[2] = 4'b0100; oh[3] = 4'b1000; oh[4] = 4'b0001;

    // Reset state, and no acceptance while reset is held
    #3;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_enc", 32'(o_enc_data), 32'd0);
    check("rst_id", 32'(o_grant_id), 32'd0);
    i_req_valid = 4'b1111;
    #1;
    check("rst_ready_held", 32'(o_req_ready), 32'd0);
    i_req_valid = '0;
    tick();
    i_rst = 1'b0;

    // Fill with lane 2 under backpressure, then reset asynchronously mid-FULL
    i_req_data[11:8] = 4'b0001;
    i_req_valid[2] = 1'b1;
    @(negedge i_clk);
    check("t1_ready_lane2", 32'(o_req_ready), 32'b0100);
    tick();
    i_req_valid[2] = 1'b0;
    check("t1_full_valid", 32'(o_valid), 32'd1);
    check("t1_full_id", 32'(o_grant_id), 32'd2);
    i_rst = 1'b1;
    #1;
    check("t1_async_valid", 32'(o_valid), 32'd0);
    check("t1_async_enc", 32'(o_enc_data), 32'd0);
    check("t1_async_id", 32'(o_grant_id), 32'd0);
    tick();
    i_rst = 1'b0;
    i_req_data = 16'h0001;
    i_req_valid = 4'b1111;
    @(negedge i_clk);
    check("t1_first_grant_lane0", 32'(o_req_ready), 32'b0001);
    push(0, cw(7'b0000111));
    tick();
    i_req_valid = '0;
    i_ready = 1'b1;
    tick();

    // Single lane 1, three data patterns
    send(1, 4'b0001, cw(7'b0000111));
    send(1, 4'b1010, cw(7'b1010010));
    send(1, 4'b0110, cw(7'b0110011));
    send(3, 4'b1111, cw(7'b1111111));   // pointer now back at 0

    // All lanes valid: grants 0,1,2,3,0 back to back
    i_req_data = 16'hFFFF;
    i_req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check("t3_rr_order", 32'(o_req_ready), 32'(oh[i]));
      check("t3_no_bubble", 32'(o_valid), 32'd1);
      push(i % 4, cw(7'b1111111));
      tick();
    end
    i_req_valid = '0;
    tick();

    // Backpressure: hold lane 2 result for 5 cycles, then pop and load lane 1
    i_ready = 1'b0;
    send(2, 4'b1010, cw(7'b1010010));
    i_req_data[7:4] = 4'b0110;
    i_req_valid[1] = 1'b1;
    push(1, cw(7'b0110011));
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check("t4_bp_ready", 32'(o_req_ready), 32'd0);
      check("t4_bp_valid", 32'(o_valid), 32'd1);
      check("t4_bp_enc", 32'(o_enc_data), 32'(cw(7'b1010010)));
      check("t4_bp_id", 32'(o_grant_id), 32'd2);
      tick();
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    check("t4_pass_ready", 32'(o_req_ready), 32'b0010);
    tick();
    i_req_valid[1] = 1'b0;
    i_ready = 1'b0;
    @(negedge i_clk);
    check("t4_reload_valid", 32'(o_valid), 32'd1);
    check("t4_reload_id", 32'(o_grant_id), 32'd1);
    check("t4_reload_enc", 32'(o_enc_data), 32'(cw(7'b0110011)));
    i_ready = 1'b1;
    tick();

    // Wrap: pointer at 3 with lanes 3 and 0 valid
    send(2, 4'b0001, cw(7'b0000111));
    i_req_data[15:12] = 4'b1111;
    i_req_data[3:0]   = 4'b0110;
    i_req_valid = 4'b1001;
    push(3, cw(7'b1111111));
    push(0, cw(7'b0110011));
    @(negedge i_clk);
    check("t5_wrap_lane3", 32'(o_req_ready), 32'b1000);
    tick();
    i_req_valid[3] = 1'b0;
    @(negedge i_clk);
    check("t5_wrap_lane0", 32'(o_req_ready), 32'b0001);
    tick();
    i_req_data[3:0] = 4'b0001;
    i_req_data[7:4] = 4'b1010;
    i_req_valid = 4'b0011;
    @(negedge i_clk);
    check("t5_ptr_at_1", 32'(o_req_ready), 32'b0010);
    push(1, cw(7'b1010010));
    tick();
    i_req_valid[1] = 1'b0;
    push(0, cw(7'b0000111));
    @(negedge i_clk);
    check("t5_ptr_wrap_lane0", 32'(o_req_ready), 32'b0001);
    tick();
    i_req_valid = '0;

`ifdef HC_ENC_RR_XPAR_EN
    // Overall parity bit
    send(0, 4'b0001, 8'b10000111);
    send(0, 4'b1111, 8'b11111111);
`endif

    // Drain, bounded
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
    tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("final_idle", 32'(o_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
